// File: rtl/dispense_scheduler.sv
// Round-robin dispense scheduler: queues slot/manual requests per channel and serialises
// fixed-width actuator pulses with an all-off gap. Define DISPENSE_MANUAL_EN to honour manual_req.
module dispense_scheduler #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned PULSE_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES   = 5000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            slot_pulse,
    input  logic [3*NUM_CH-1:0]   sched_mask,
    input  logic [NUM_CH-1:0]     manual_req,
    output logic [NUM_CH-1:0]     dispense_out,
    output logic                  busy,
    output logic [2:0]            active_ch,
    output logic [NUM_CH-1:0]     pending,
    output logic                  done_pulse,
    output logic [NUM_CH-1:0]     overrun
);
    localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        rr_ptr;
    logic [2:0]        grant_idx;
    logic              grant;
    logic [NUM_CH-1:0] manual_eff, req, grant_clr;
    logic [NUM_CH-1:0] dispense_nxt;
    logic              busy_nxt, done_nxt;

`ifdef DISPENSE_MANUAL_EN
    assign manual_eff = manual_req;
`else
    logic unused_manual;
    assign manual_eff    = '0;
    assign unused_manual = ^manual_req;
`endif

    // Per-channel request: any enabled slot pulse or a manual request, merged into one.
    always_comb begin
        req = manual_eff;
        for (int i = 0; i < NUM_CH; i++) begin
            if (|(slot_pulse & sched_mask[3*i +: 3])) req[i] = 1'b1;
        end
    end

    // First pending channel at or above rr_ptr, else lowest pending channel (wrap).
    always_comb begin
        logic       hi_found;
        logic [2:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant_clr = grant ? (NUM_CH'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: if (|pending) begin
                grant     = 1'b1;
                state_nxt = FIRE;
            end
            FIRE: if (cnt == '0) state_nxt = GAP;
            GAP:  if (cnt == '0) begin
                if (|pending) begin
                    grant     = 1'b1;
                    state_nxt = FIRE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs lag the state by one register stage.
    always_comb begin
        dispense_nxt = '0;
        busy_nxt     = (state != IDLE);
        done_nxt     = (|dispense_out) && (state != FIRE);
        if (state == FIRE) dispense_nxt = NUM_CH'(1) << active_ch;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dispense_out <= '0;
            busy         <= 1'b0;
            done_pulse   <= 1'b0;
            pending      <= '0;
            overrun      <= '0;
            active_ch    <= '0;
            rr_ptr       <= '0;
            cnt          <= '0;
        end else begin
            dispense_out <= dispense_nxt;
            busy         <= busy_nxt;
            done_pulse   <= done_nxt;
            pending      <= (pending & ~grant_clr) | req;
            overrun      <= overrun | (req & pending & ~grant_clr);
            if (grant) begin
                active_ch <= grant_idx;
                rr_ptr    <= (grant_idx == LAST_CH) ? 3'd0 : grant_idx + 3'd1;
            end
            if (grant)                             cnt <= PULSE_LOAD;
            else if (state == FIRE && cnt == '0)   cnt <= GAP_LOAD;
            else if (cnt != '0)                    cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler (NUM_CH=4, P=4, G=2): cycle table for the basic dispense,
// scoreboard of expected pulse order for arbitration, overrun, requeue and reset cases.
module tb_dispense_scheduler;
    localparam int unsigned NCH = 4;
    localparam int unsigned P   = 4;
    localparam int unsigned G   = 2;
`ifdef DISPENSE_MANUAL_EN
    localparam logic [NCH-1:0] MAN_PEND = 4'b1111;
`else
    localparam logic [NCH-1:0] MAN_PEND = 4'b0000;
`endif

    logic             clock;
    logic             reset;
    logic [2:0]       slot_pulse;
    logic [3*NCH-1:0] sched_mask;
    logic [NCH-1:0]   manual_req;
    logic [NCH-1:0]   dispense_out;
    logic             busy;
    logic [2:0]       active_ch;
    logic [NCH-1:0]   pending;
    logic             done_pulse;
    logic [NCH-1:0]   overrun;

    dispense_scheduler #(.NUM_CH(NCH), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .slot_pulse(slot_pulse), .sched_mask(sched_mask),
        .manual_req(manual_req), .dispense_out(dispense_out), .busy(busy),
        .active_ch(active_ch), .pending(pending), .done_pulse(done_pulse), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];
    logic [NCH-1:0] prev_disp = '0;

    typedef struct {
        logic           rst;
        logic [2:0]     slot;
        logic [NCH-1:0] disp;
        logic           busy;
        logic [NCH-1:0] pend;
        logic           done;
        logic [2:0]     act;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic r, input logic [2:0] s, input logic [NCH-1:0] d,
                                input logic b, input logic [NCH-1:0] p, input logic dn,
                                input logic [2:0] a);
        vec_t v;
        v.rst = r; v.slot = s; v.disp = d; v.busy = b; v.pend = p; v.done = dn; v.act = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] s, input logic [NCH-1:0] m);
        slot_pulse = s;
        manual_req = m;
        @(negedge clock);
        slot_pulse = '0;
        manual_req = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || pending != '0 || dispense_out != '0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, n);
        end
    endtask

    // Scoreboard: every rising drive must match the next expected channel, one-hot.
    always @(negedge clock) begin
        logic [NCH-1:0] want;
        if (dispense_out != '0) begin
            total++;
            if ($countones(dispense_out) != 1) begin
                bad++;
                $display("FAIL onehot: got 0x%0h, want a single bit", dispense_out);
            end
        end
        if (dispense_out != '0 && prev_disp == '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_order: got 0x%0h, want no pulse", dispense_out);
            end else begin
                want = NCH'(1) << exp_q.pop_front();
                if (dispense_out !== want) begin
                    bad++;
                    $display("FAIL pulse_order: got 0x%0h, want 0x%0h", dispense_out, want);
                end
            end
        end
        prev_disp = dispense_out;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    int n;
    int lows;

    initial begin
        reset      = 1'b1;
        slot_pulse = '0;
        manual_req = '0;
        sched_mask = 12'h041;
        // Basic slot dispense: ch0 and ch2 morning, slot on edge 0.
        vecs[0]  = mk(1, 3'b000, 4'b0000, 0, 4'b0000, 0, 3'd0);
        vecs[1]  = mk(0, 3'b001, 4'b0000, 0, 4'b0101, 0, 3'd0);
        vecs[2]  = mk(0, 3'b000, 4'b0000, 0, 4'b0100, 0, 3'd0);
        vecs[3]  = mk(0, 3'b000, 4'b0001, 1, 4'b0100, 0, 3'd0);
        vecs[4]  = mk(0, 3'b000, 4'b0001, 1, 4'b0100, 0, 3'd0);
        vecs[5]  = mk(0, 3'b000, 4'b0001, 1, 4'b0100, 0, 3'd0);
        vecs[6]  = mk(0, 3'b000, 4'b0001, 1, 4'b0100, 0, 3'd0);
        vecs[7]  = mk(0, 3'b000, 4'b0000, 1, 4'b0100, 1, 3'd0);
        vecs[8]  = mk(0, 3'b000, 4'b0000, 1, 4'b0000, 0, 3'd2);
        vecs[9]  = mk(0, 3'b000, 4'b0100, 1, 4'b0000, 0, 3'd2);
        vecs[10] = mk(0, 3'b000, 4'b0100, 1, 4'b0000, 0, 3'd2);
        vecs[11] = mk(0, 3'b000, 4'b0100, 1, 4'b0000, 0, 3'd2);
        vecs[12] = mk(0, 3'b000, 4'b0100, 1, 4'b0000, 0, 3'd2);
        vecs[13] = mk(0, 3'b000, 4'b0000, 1, 4'b0000, 1, 3'd2);
        vecs[14] = mk(0, 3'b000, 4'b0000, 1, 4'b0000, 0, 3'd2);
        vecs[15] = mk(0, 3'b000, 4'b0000, 0, 4'b0000, 0, 3'd2);
        @(negedge clock);
        exp_q.push_back(0);
        exp_q.push_back(2);
        for (int i = 0; i < 16; i++) begin
            reset      = vecs[i].rst;
            slot_pulse = vecs[i].slot;
            @(negedge clock);
            check($sformatf("row%0d_disp", i), 32'(dispense_out), 32'(vecs[i].disp));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("row%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
            check($sformatf("row%0d_done", i), 32'(done_pulse), 32'(vecs[i].done));
            check($sformatf("row%0d_act", i), 32'(active_ch), 32'(vecs[i].act));
        end
        slot_pulse = '0;
        check("tbl_overrun", 32'(overrun), 32'(0));

        // Round robin: ch1 alone sets rr_ptr=2, then ch1+ch3 -> ch3 first; then ch0+ch1 -> ch0 first.
        sched_mask = 12'h43C;
        exp_q.push_back(1);
        pulse(3'b001, '0);
        repeat (2) @(negedge clock);
        exp_q.push_back(3);
        exp_q.push_back(1);
        pulse(3'b010, '0);
        wait_idle("rr1");
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse(3'b100, '0);
        check("rr2_pend", 32'(pending), 32'(4'b0011));
        wait_idle("rr2");
        check("rr_overrun", 32'(overrun), 32'(0));

        // Overrun: ch1 hit twice more while still queued behind ch0.
        sched_mask = 12'h02C;
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse(3'b100, '0);
        pulse(3'b001, '0);
        pulse(3'b001, '0);
        check("ovr_set", 32'(overrun), 32'(4'b0010));
        check("ovr_pend", 32'(pending), 32'(4'b0010));
        wait_idle("ovr");
        check("ovr_sticky", 32'(overrun), 32'(4'b0010));

        // Same-cycle merge of slot and manual request on ch2.
        sched_mask = 12'h040;
        exp_q.push_back(2);
        pulse(3'b001, 4'b0100);
        check("merge_pend", 32'(pending), 32'(4'b0100));
        check("merge_ovr", 32'(overrun), 32'(4'b0010));
        wait_idle("merge");
        check("merge_ovr_end", 32'(overrun), 32'(4'b0010));

        // Requeue of ch0 while it is firing; second pulse follows after exactly G low cycles.
        sched_mask = 12'h001;
        exp_q.push_back(0);
        exp_q.push_back(0);
        pulse(3'b001, '0);
        n = 0;
        while (dispense_out !== 4'b0001 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rq_first_rise", 32'(dispense_out), 32'(4'b0001));
`ifdef DISPENSE_MANUAL_EN
        pulse(3'b000, 4'b0001);
`else
        pulse(3'b001, '0);
`endif
        check("rq_pend", 32'(pending), 32'(4'b0001));
        check("rq_ovr", 32'(overrun), 32'(4'b0010));
        n = 0;
        while (dispense_out != '0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        lows = 0;
        while (dispense_out == '0 && lows < 20) begin
            @(negedge clock);
            lows++;
        end
        check("rq_gap_lows", 32'(lows), 32'(G));
        check("rq_second", 32'(dispense_out), 32'(4'b0001));
        wait_idle("rq");

        // Reset in the 2nd FIRE cycle of ch0 with ch1 and ch2 queued.
        sched_mask = 12'h091;
        exp_q.push_back(0);
        pulse(3'b001, '0);
        pulse(3'b010, '0);
        @(negedge clock);
        check("rst_pre_disp", 32'(dispense_out), 32'(4'b0001));
        check("rst_pre_pend", 32'(pending), 32'(4'b0110));
        reset = 1'b1;
        @(negedge clock);
        check("rst_disp", 32'(dispense_out), 32'(0));
        check("rst_pend", 32'(pending), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        check("rst_act", 32'(active_ch), 32'(0));
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_after_disp", 32'(dispense_out), 32'(0));
        check("rst_after_pend", 32'(pending), 32'(0));
        check("rst_after_busy", 32'(busy), 32'(0));

        // All manual requests at once: honoured only with DISPENSE_MANUAL_EN.
`ifdef DISPENSE_MANUAL_EN
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
`endif
        pulse(3'b000, 4'b1111);
        check("man_pend", 32'(pending), 32'(MAN_PEND));
        wait_idle("man");
        repeat (5) @(negedge clock);
        check("man_disp_end", 32'(dispense_out), 32'(0));
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Central scheduler that turns dispense-time slot pulses (morning/afternoon/evening) and optional manual requests into timed actuator pulses on a set of dispenser channels. Only one channel may drive its actuator at a time because the motors share one supply, so the block queues requests per channel and serialises them with a round-robin arbiter. Each granted channel gets a fixed-width drive pulse followed by a mandatory all-off gap. It sits between the dispense-time comparator and the GPIO actuator pins, replacing the per-channel free-running pulse stretchers.

## Interface
Parameters:
- NUM_CH, 4: number of dispenser channels, 2..8.
- PULSE_CYCLES, 50000000: actuator on-time in clock cycles, ≥1.
- GAP_CYCLES, 5000000: all-off gap after each pulse in clock cycles, ≥1.

Ports:
- clock, in, 1: system clock (50 MHz).
- reset, in, 1: synchronous, active-high.
- slot_pulse, in, 3: one-cycle pulses. Bit 0 is morning, bit 1 afternoon, bit 2 evening.
- sched_mask, in, 3*NUM_CH: bits [3i+2:3i] are the slot enables for channel i. Sampled only in the cycle a slot pulse arrives.
- manual_req, in, NUM_CH: one-cycle manual dispense request per channel.
- dispense_out, out, NUM_CH: actuator drive, registered. At most one bit is ever high.
- busy, out, 1: high in FIRE or GAP.
- active_ch, out, 3: index of the last granted channel.
- pending, out, NUM_CH: queued requests.
- done_pulse, out, 1: one-cycle strobe on the cycle a drive pulse ends.
- overrun, out, NUM_CH: sticky. Set when a request hits a channel whose pending bit is already set.

## Operation
- Request for channel i in a cycle:
  - req_i = |(slot_pulse & sched_mask[3i+2:3i]) | manual_req[i].
  - Multiple sources in the same cycle merge into one request, with no overrun.
- pending[i] is set on the edge a request is sampled.
  - If pending[i] is already 1, the request is dropped and overrun[i] is set.
  - Overrun is cleared only by reset.
- A request for the channel currently firing is legal. Its pending bit was cleared at grant, so the request queues again.
- FSM states:
  - IDLE: if pending≠0, grant and go to FIRE; otherwise stay in IDLE.
  - FIRE: drive dispense_out[g] for exactly PULSE_CYCLES cycles, then go to GAP.
  - GAP: all outputs low for exactly GAP_CYCLES cycles. On the last gap cycle, grant directly into FIRE if pending≠0; otherwise go to IDLE.
- Grant:
  - Choose the first set pending bit, searching upward from rr_ptr and wrapping at NUM_CH.
  - Clear that pending bit, load active_ch, and set rr_ptr = (g+1) mod NUM_CH.
  - A request arriving on the grant edge for the granted channel re-sets its pending bit without overrun.
- done_pulse is high for the one cycle following the falling edge of dispense_out.
- Arithmetic:
  - A single down-counter, width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
  - It loads P-1 or G-1 and transitions when it reaches 0. No wrap-around is possible.
- Reset values:
  - state IDLE, dispense_out 0, pending 0, overrun 0.
  - busy 0, active_ch 0, done_pulse 0, rr_ptr 0, counter 0.
- Reset mid-pulse: dispense_out drops on the reset edge and all queued requests are discarded.

## Timing
- Request sampled on edge n: pending visible after edge n; dispense_out rises after edge n+2 when the block is idle.
- Drive is high for exactly PULSE_CYCLES cycles and falls after edge n+2+P.
- The next queued channel rises after edge n+2+P+G. There is no extra IDLE cycle between back-to-back grants.
- busy rises with dispense_out and falls after the final GAP cycle.
- Worst-case wait for a queued channel: (NUM_CH-1)·(P+G)+1 cycles.

## Configuration
- DISPENSE_MANUAL_EN defined: manual_req behaves as described above.
- Not defined:
  - manual_req is ignored internally. The port remains, for a stable top-level pinout.
  - Only slot pulses gated by sched_mask create requests.

## Test plan
Bench parameters: NUM_CH=4, P=4, G=2.

- Basic slot dispense: sched_mask ch0 and ch2 morning only; slot_pulse=001 on edge 0.
  - ch0 high after edges 2–5, falls after edge 6.
  - ch2 high after edge 8, falls after edge 12.
  - done_pulse after edges 6 and 12; busy low after edge 14.
- Round-robin order: pending ch1 and ch3, rr_ptr=2 → ch3 is served first, then ch1.
  - Then, with ch0 and ch1 queued, ch0 is served first.
- Overrun and same-cycle merge: two slot pulses to ch1 while it is still queued → single pulse, overrun[1]=1.
  - Simultaneous manual and slot request on ch2 → one pulse, overrun[2]=0.
- Reset mid-operation: assert reset at the 2nd FIRE cycle with ch1 and ch2 pending.
  - dispense_out=0 and pending=0 after the reset edge; no later pulses occur.
- Requeue during fire: manual_req[0] while ch0 is firing → a second ch0 pulse starts after edge (fall+2) with no overrun.
- Macro off: manual_req=1111 with DISPENSE_MANUAL_EN undefined → pending stays 0 and dispense_out stays 0.
